data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/mips_pkg.sv | 30 +++
 rtl/data_mem_array.sv | 25 ++
 rtl/data_mem.sv | 146 ++++++++++++++
 tb/tb_data_mem.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: data-memory geometry, access-size encodings and
// the legality rule used by both the ALU-side control and the data memory.
package mips_pkg;

    localparam int DMEM_DEPTH     = 256;
    localparam int DMEM_ADDR_BITS = $clog2(DMEM_DEPTH);

    typedef enum logic [1:0] {
        ACC_BYTE = 2'b00,
        ACC_HALF = 2'b01,
        ACC_WORD = 2'b10,
        ACC_ILL  = 2'b11
    } acc_size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } dmem_state_e;

    // Natural alignment: halves on even bytes, words on 4-byte boundaries.
    function automatic logic acc_legal(input logic [1:0] size, input logic [1:0] off);
        case (acc_size_e'(size))
            ACC_BYTE: return 1'b1;
            ACC_HALF: return ~off[0];
            ACC_WORD: return (off == 2'b00);
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-organised storage with a byte-enable write port and an asynchronous
// read port. Byte enable bit 3 maps to bits [31:24] (big-endian offset 0).
module data_mem_array #(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic [3:0]           i_be,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [31:0]          i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [31:0]          o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_mem.sv
// MIPS data memory: big-endian byte/half/word load-store unit with alignment
// fault capture and a post-reset zeroing sweep before accesses are accepted.
module data_mem
    import mips_pkg::*;
#(
    parameter int DEPTH     = DMEM_DEPTH,
    parameter int ADDR_BITS = DMEM_ADDR_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  accSize,
    input  logic        loadUnsigned,
    output logic [31:0] readData,
    output logic        ready,
    output logic        misaligned,
    output logic [31:0] faultAddr
);

    dmem_state_e          r_state, w_state_nxt;
    logic [ADDR_BITS-1:0] r_sweep_cnt;
    logic                 r_misaligned;
    logic [31:0]          r_fault_addr;

    logic                 w_ready, w_sweep;
    logic [1:0]           w_off;
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_legal, w_access, w_fault;
    logic [3:0]           w_st_be, w_be;
    logic [31:0]          w_st_data, w_wdata, w_rword;
    logic [ADDR_BITS-1:0] w_waddr;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;

    // FSM: sweep every word to zero, then serve accesses until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_CLEAR;
            r_sweep_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_sweep) r_sweep_cnt <= r_sweep_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_sweep     = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_sweep = rst_n;
                if (r_sweep_cnt == ADDR_BITS'(DEPTH - 1)) w_state_nxt = ST_RUN;
            end
            ST_RUN:   w_ready = 1'b1;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    assign w_off    = address[1:0];
    assign w_idx    = address[ADDR_BITS+1:2];
    assign w_legal  = acc_legal(accSize, w_off);
    assign w_access = (memRead | memWrite) & w_ready;
    assign w_fault  = w_access & ~w_legal;

    // Store lane steering: replicate the low bits, enable only the target lanes.
    always_comb begin
        w_st_be   = 4'b0000;
        w_st_data = writeData;
        case (acc_size_e'(accSize))
            ACC_BYTE: begin
                w_st_be   = 4'b1000 >> w_off;
                w_st_data = {4{writeData[7:0]}};
            end
            ACC_HALF: begin
                w_st_be   = w_off[1] ? 4'b0011 : 4'b1100;
                w_st_data = {2{writeData[15:0]}};
            end
            ACC_WORD: w_st_be = 4'b1111;
            default:  w_st_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_waddr = w_idx;
        w_wdata = w_st_data;
        w_be    = 4'b0000;
        if (w_sweep) begin
            w_waddr = r_sweep_cnt;
            w_wdata = '0;
            w_be    = 4'b1111;
        end else if (memWrite && w_ready && w_legal) begin
            w_be = w_st_be;
        end
    end

    data_mem_array #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .i_be    (w_be),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_rword)
    );

    // Load lane selection and extension; array read reflects pre-edge contents.
    always_comb begin
        case (w_off)
            2'd0:    w_byte = w_rword[31:24];
            2'd1:    w_byte = w_rword[23:16];
            2'd2:    w_byte = w_rword[15:8];
            default: w_byte = w_rword[7:0];
        endcase
        w_half   = w_off[1] ? w_rword[15:0] : w_rword[31:16];
        readData = '0;
        if (memRead && w_ready && w_legal) begin
            case (acc_size_e'(accSize))
                ACC_BYTE: readData = {{24{~loadUnsigned & w_byte[7]}}, w_byte};
                ACC_HALF: readData = {{16{~loadUnsigned & w_half[15]}}, w_half};
                default:  readData = w_rword;
            endcase
        end
    end

    // Sticky fault: the first illegal address is kept until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
            r_fault_addr <= '0;
        end else if (w_fault) begin
            r_misaligned <= 1'b1;
            if (!r_misaligned) r_fault_addr <= address;
        end
    end

    assign ready      = w_ready;
    assign misaligned = r_misaligned;
    assign faultAddr  = r_fault_addr;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: vector table for load/store/fault behaviour,
// plus hand sequences for the reset sweep timing and reset-during-sweep.
module tb_data_mem;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] address, writeData;
    logic        memRead, memWrite, loadUnsigned;
    logic [1:0]  accSize;
    logic [31:0] readData, faultAddr;
    logic        ready, misaligned;

    always #5 clk = ~clk;

    data_mem #(.DEPTH(256), .ADDR_BITS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .writeData    (writeData),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .accSize      (accSize),
        .loadUnsigned (loadUnsigned),
        .readData     (readData),
        .ready        (ready),
        .misaligned   (misaligned),
        .faultAddr    (faultAddr)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_mis;
        logic [31:0] exp_fa;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cnt;

    function automatic vec_t mk(logic rd, logic wr, logic [1:0] sz, logic uns,
                                logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] exp_rd, logic exp_mis, logic [31:0] exp_fa);
        vec_t v;
        v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_mis = exp_mis; v.exp_fa = exp_fa;
        return v;
    endfunction

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        memRead = 1'b0; memWrite = 1'b0; accSize = 2'b10; loadUnsigned = 1'b0;
        address = '0; writeData = '0;
    endtask

    // Drive at negedge, check readData before the edge and flags after it.
    task automatic apply(input vec_t v, input int k);
        @(negedge clk);
        memRead = v.rd; memWrite = v.wr; accSize = v.sz; loadUnsigned = v.uns;
        address = v.addr; writeData = v.wdata;
        #1;
        check32($sformatf("v%0d readData", k), readData, v.exp_rd);
        check32($sformatf("v%0d ready", k), {31'b0, ready}, 32'd1);
        @(posedge clk);
        #1;
        check32($sformatf("v%0d misaligned", k), {31'b0, misaligned}, {31'b0, v.exp_mis});
        check32($sformatf("v%0d faultAddr", k), faultAddr, v.exp_fa);
        idle();
    endtask

    // Called just after rst_n is released at a negedge; counts ready=0 cycles.
    task automatic count_sweep(output int c);
        c = 0;
        #1;
        while (ready == 1'b0 && c < 600) begin
            c++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;

        // Table: B=00 H=01 W=10 X=11
        tbl.push_back(mk(1,0,2'b10,0,32'h3FC,32'h0,        32'h00000000,0,32'h0));
        tbl.push_back(mk(0,1,2'b10,0,32'h010,32'hDEADBEEF, 32'h00000000,0,32'h0));
        tbl.push_back(mk(1,0,2'b10,0,32'h010,32'h0,        32'hDEADBEEF,0,32'h0));
        tbl.push_back(mk(0,1,2'b00,0,32'h013,32'h00000080, 32'h00000000,0,32'h0));
        tbl.push_back(mk(1,0,2'b00,0,32'h013,32'h0,        32'hFFFFFF80,0,32'h0));
        tbl.push_back(mk(1,0,2'b00,1,32'h013,32'h0,        32'h00000080,0,32'h0));
        tbl.push_back(mk(1,0,2'b10,0,32'h010,32'h0,        32'hDEADBE80,0,32'h0));
        tbl.push_back(mk(1,0,2'b01,0,32'h010,32'h0,        32'hFFFFDEAD,0,32'h0));
        tbl.push_back(mk(1,0,2'b01,1,32'h012,32'h0,        32'h0000BE80,0,32'h0));
        tbl.push_back(mk(1,0,2'b00,0,32'h010,32'h0,        32'hFFFFFFDE,0,32'h0));
        tbl.push_back(mk(1,0,2'b00,1,32'h011,32'h0,        32'h000000AD,0,32'h0));
        tbl.push_back(mk(0,1,2'b01,0,32'h012,32'hFFFF8001, 32'h00000000,0,32'h0));
        tbl.push_back(mk(1,0,2'b10,0,32'h010,32'h0,        32'hDEAD8001,0,32'h0));
        tbl.push_back(mk(1,0,2'b01,0,32'h012,32'h0,        32'hFFFF8001,0,32'h0));
        tbl.push_back(mk(1,1,2'b10,0,32'h010,32'h55AA55AA, 32'hDEAD8001,0,32'h0));
        tbl.push_back(mk(1,0,2'b10,0,32'h010,32'h0,        32'h55AA55AA,0,32'h0));
        tbl.push_back(mk(1,0,2'b10,0,32'h020,32'h0,        32'h00000000,0,32'h0));
        tbl.push_back(mk(0,1,2'b10,0,32'h022,32'h12345678, 32'h00000000,1,32'h22));
        tbl.push_back(mk(1,0,2'b10,0,32'h020,32'h0,        32'h00000000,1,32'h22));
        tbl.push_back(mk(1,0,2'b01,0,32'h031,32'h0,        32'h00000000,1,32'h22));
        tbl.push_back(mk(1,0,2'b10,0,32'h012,32'h0,        32'h00000000,1,32'h22));
        tbl.push_back(mk(1,0,2'b11,0,32'h010,32'h0,        32'h00000000,1,32'h22));
        tbl.push_back(mk(0,1,2'b10,0,32'h400,32'h11111111, 32'h00000000,1,32'h22));
        tbl.push_back(mk(1,0,2'b10,0,32'h000,32'h0,        32'h11111111,1,32'h22));
        tbl.push_back(mk(1,0,2'b10,0,32'h800,32'h0,        32'h11111111,1,32'h22));
        tbl.push_back(mk(0,0,2'b10,0,32'h010,32'h0,        32'h00000000,1,32'h22));

        // Reset state and sweep length
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1;
        check32("reset ready", {31'b0, ready}, 32'd0);
        check32("reset misaligned", {31'b0, misaligned}, 32'd0);
        check32("reset faultAddr", faultAddr, 32'h0);
        rst_n = 1'b1;
        count_sweep(cnt);
        check32("sweep cycles", cnt, 32'd256);

        foreach (tbl[i]) apply(tbl[i], i);

        // Reset mid-sweep restarts it; accesses during CLEAR are ignored.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check32("rst2 misaligned", {31'b0, misaligned}, 32'd0);
        check32("rst2 faultAddr", faultAddr, 32'h0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        #1;
        while (ready == 1'b0 && cnt < 600) begin
            cnt++;
            idle();
            if (cnt == 200) begin
                memWrite = 1'b1; address = 32'h40; writeData = 32'hCAFEF00D;
            end
            if (cnt == 201) begin
                memRead = 1'b1; address = 32'h10;
                #1;
                check32("clear readData", readData, 32'h0);
            end
            if (cnt == 202) begin
                memRead = 1'b1; accSize = 2'b01; address = 32'h41;
            end
            if (cnt == 203) check32("clear no fault", {31'b0, misaligned}, 32'd0);
            @(negedge clk);
            #1;
        end
        idle();
        check32("resweep cycles", cnt, 32'd256);
        apply(mk(1,0,2'b10,0,32'h040,32'h0,32'h00000000,0,32'h0), 100);
        apply(mk(1,0,2'b10,0,32'h000,32'h0,32'h00000000,0,32'h0), 101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
